lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- T_PWRUP, 750000, power-up wait in cycles.
- T_SETUP, 4, RS/DATA setup before EN rises.
- T_PULSE, 12, EN high width.
- T_HOLD, 4, data hold after EN falls.
- T_EXEC, 1850, execution wait for normal commands and data.
- T_LONG, 76000, execution wait for clear/home.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- wr_en, in, 1, core write strobe (single cycle per entry).
- wr_data, in, 9, bit 8 = RS, bits 7:0 = byte.
- full, out, 1, FIFO holds 4 entries.
- busy, out, 1, FSM not in IDLE or FIFO non-empty.
- init_done, out, 1, power-up sequence complete.
- ovf, out, 1, sticky: a write was dropped.
- lcd_on, out, 1, panel power enable.
- lcd_en, out, 1, HD44780 EN.
- lcd_rs, out, 1, HD44780 RS.
- lcd_rw, out, 1, HD44780 RW, constant 0.
- lcd_data, out, 8, HD44780 DB7..DB0.

Function
REQ-004 The command FIFO SHALL be 4 entries deep, 9 bits wide, first-in first-out, with wrap-around pointers and a 3-bit count.
REQ-005 A write with wr_en=1 and full=0 SHALL push wr_data; a write with full=1 SHALL be dropped and set ovf, even if a pop occurs in the same cycle.
REQ-006 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-007 The FSM states SHALL be PWRUP, INIT, IDLE, SETUP, PULSE, HOLD and EXEC.
REQ-008 PWRUP SHALL wait T_PWRUP cycles with lcd_on=1, then go to INIT.
REQ-009 INIT SHALL issue 0x38, 0x0C, 0x01, 0x06 (all with RS=0) in order, each through SETUP/PULSE/HOLD/EXEC, then set init_done and go to IDLE.
REQ-010 The FIFO SHALL accept writes during PWRUP and INIT, but SHALL NOT be popped before init_done=1.
REQ-011 In IDLE with a non-empty FIFO, the FSM SHALL pop one entry, register its RS and byte onto lcd_rs/lcd_data, and enter SETUP.
REQ-012 If wr_en is sampled in cycle c into an empty FIFO while in IDLE, lcd_data SHALL be valid from cycle c+2.
REQ-013 SETUP SHALL last T_SETUP cycles with lcd_en=0; PULSE SHALL last T_PULSE cycles with lcd_en=1; HOLD SHALL last T_HOLD cycles with lcd_en=0.
REQ-014 lcd_rs and lcd_data SHALL be stable from SETUP through the end of HOLD.
REQ-015 EXEC SHALL last T_LONG cycles when RS=0 and the byte is 0x01, 0x02 or 0x03, and T_EXEC cycles otherwise; it SHALL then return to IDLE, or to the next INIT step during initialisation.
REQ-016 Back-to-back FIFO entries SHALL proceed from EXEC to IDLE to SETUP without extra idle cycles beyond the single IDLE cycle.
REQ-017 A single down-counter of 20 bits SHALL time every state; it SHALL load on state entry and the state SHALL exit when the counter reaches 0.
REQ-018 lcd_rw SHALL always be 0; the block SHALL NOT read back the LCD busy flag.

Reset
REQ-019 Assertion of rst SHALL immediately force: state=PWRUP, FIFO empty, ovf=0, init_done=0, lcd_on=0, lcd_en=0, lcd_rs=0, lcd_data=0x00, full=0, busy=1.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer, drop lcd_en to 0 asynchronously, and restart the full power-up sequence after deassertion.
REQ-021 lcd_on SHALL become 1 at the first clock edge after rst deasserts.

Structure
REQ-022 A shared package lcd_pkg SHALL hold the state enum, the 4-entry init-command table and the long-command byte list.
REQ-023 The FIFO SHALL be a sub-module named lcd_fifo (parameterised depth and width); the FSM and counter SHALL stay in lcd_ctrl.

Verification
Benches SHALL use T_PWRUP=20, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=10 and T_LONG=40.
REQ-024 Reset release -> lcd_en pulses exactly 4 times with bytes 0x38, 0x0C, 0x01, 0x06; the gap after 0x01 is 40 cycles; init_done rises afterwards.
REQ-025 After init, one write of 0x141 -> lcd_rs=1 and lcd_data=0x41 two cycles later; lcd_en high for exactly 4 cycles after 2 setup cycles; busy falls after EXEC.
REQ-026 Six writes issued during PWRUP -> full after 4, ovf=1, and only the first 4 bytes appear on the bus, in order.
REQ-027 Write of 0x001 followed by 0x002 -> each is followed by a 40-cycle EXEC; write of 0x102 -> 10-cycle EXEC.
REQ-028 rst asserted during PULSE -> lcd_en=0 in the same cycle; after deassertion the init sequence repeats from 0x38.
REQ-029 Push while full coinciding with a pop -> write dropped, count goes from 4 to 3, ovf set.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller.
// Holds the FSM state set, the power-up command table and long-command list.
package lcd_pkg;

   localparam int CNT_W = 20;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT,
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_EXEC
   } state_e;

   // Entry 0 is issued first: function set, display on, clear, entry mode.
   localparam logic [3:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

   localparam logic [2:0][7:0] LONG_CMDS = {8'h03, 8'h02, 8'h01};

   function automatic logic is_long(input logic rs, input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (b == LONG_CMDS[i]) hit = 1'b1;
      end
      return !rs && hit;
   endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small command FIFO with wrap-around pointers; pushes into a full FIFO
// are ignored even when a pop happens in the same cycle.
module lcd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push)
            wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
         if (do_pop)
            rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up wait, init sequence, then
// drains queued RS/byte entries with SETUP/PULSE/HOLD/EXEC timing.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 4,
   parameter int T_PULSE = 12,
   parameter int T_HOLD  = 4,
   parameter int T_EXEC  = 1850,
   parameter int T_LONG  = 76000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       init_done,
   output logic       ovf,
   output logic       lcd_on,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       idx_q;
   logic             init_done_q;
   logic             ovf_q;
   logic             lcd_on_q;
   logic             lcd_en_q;
   logic             lcd_rs_q;
   logic [7:0]       lcd_data_q;

   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [8:0] fifo_rdata;

   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty && init_done_q;

   lcd_fifo #(
      .DEPTH(4),
      .WIDTH(9)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (wr_en),
      .pop_i  (fifo_pop),
      .wdata_i(wr_data),
      .rdata_o(fifo_rdata),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else if (wr_en && fifo_full) ovf_q <= 1'b1;
   end

   // Each timed state loads cnt_q on entry and leaves once it reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_PWRUP;
         cnt_q       <= PWRUP_LD;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         lcd_on_q    <= 1'b0;
         lcd_en_q    <= 1'b0;
         lcd_rs_q    <= 1'b0;
         lcd_data_q  <= '0;
      end else begin
         lcd_on_q <= 1'b1;
         unique case (state_q)
            S_PWRUP: begin
               if (cnt_q == '0) state_q <= S_INIT;
               else cnt_q <= cnt_q - 1'b1;
            end
            S_INIT: begin
               lcd_rs_q   <= 1'b0;
               lcd_data_q <= INIT_CMDS[idx_q];
               cnt_q      <= SETUP_LD;
               state_q    <= S_SETUP;
            end
            S_IDLE: begin
               if (fifo_pop) begin
                  lcd_rs_q   <= fifo_rdata[8];
                  lcd_data_q <= fifo_rdata[7:0];
                  cnt_q      <= SETUP_LD;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  lcd_en_q <= 1'b1;
                  cnt_q    <= PULSE_LD;
                  state_q  <= S_PULSE;
               end else cnt_q <= cnt_q - 1'b1;
            end
            S_PULSE: begin
               if (cnt_q == '0) begin
                  lcd_en_q <= 1'b0;
                  cnt_q    <= HOLD_LD;
                  state_q  <= S_HOLD;
               end else cnt_q <= cnt_q - 1'b1;
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  cnt_q   <= is_long(lcd_rs_q, lcd_data_q) ? LONG_LD : EXEC_LD;
                  state_q <= S_EXEC;
               end else cnt_q <= cnt_q - 1'b1;
            end
            S_EXEC: begin
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
               else if (init_done_q) state_q <= S_IDLE;
               else if (idx_q == 2'd3) begin
                  init_done_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= S_INIT;
               end
            end
            default: state_q <= S_PWRUP;
         endcase
      end
   end

   assign full      = fifo_full;
   assign busy      = (state_q != S_IDLE) || !fifo_empty;
   assign init_done = init_done_q;
   assign ovf       = ovf_q;
   assign lcd_on    = lcd_on_q;
   assign lcd_en    = lcd_en_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl using shortened timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lcd_ctrl;

   localparam int T_PWRUP = 20;
   localparam int T_SETUP = 2;
   localparam int T_PULSE = 4;
   localparam int T_HOLD  = 2;
   localparam int T_EXEC  = 10;
   localparam int T_LONG  = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [8:0] wr_data = '0;
   logic       full, busy, init_done, ovf;
   logic       lcd_on, lcd_en, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   int n_cmp = 0;
   int n_err = 0;

   lcd_ctrl #(
      .T_PWRUP(T_PWRUP),
      .T_SETUP(T_SETUP),
      .T_PULSE(T_PULSE),
      .T_HOLD (T_HOLD),
      .T_EXEC (T_EXEC),
      .T_LONG (T_LONG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .busy     (busy),
      .init_done(init_done),
      .ovf      (ovf),
      .lcd_on   (lcd_on),
      .lcd_en   (lcd_en),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [8:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Waits for an EN pulse (w = low cycles seen first), then measures it.
   task automatic xfer(input string tag, input logic [7:0] ed,
                       input logic ers, input int ew);
      logic [7:0] d;
      logic       rs;
      int         w, h;
      bit         st;
      w  = 0;
      h  = 0;
      st = 1'b1;
      while (lcd_en !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      d  = lcd_data;
      rs = lcd_rs;
      while (lcd_en === 1'b1 && h < 100) begin
         @(negedge clk);
         h++;
         if (lcd_data !== d || lcd_rs !== rs) st = 1'b0;
      end
      chk({tag, ".data"}, 32'(d), 32'(ed));
      chk({tag, ".rs"}, 32'(rs), 32'(ers));
      chk({tag, ".en_width"}, h, T_PULSE);
      chk({tag, ".stable"}, 32'(st), 1);
      if (ew >= 0) chk({tag, ".gap"}, w, ew);
   endtask

   // Called right after a pulse ends: busy must drop exactly after EXEC.
   task automatic exec_len(input string tag, input int ex);
      step(T_HOLD + ex - 1);
      chk({tag, ".busy_hi"}, 32'(busy), 1);
      step(1);
      chk({tag, ".busy_lo"}, 32'(busy), 0);
   endtask

   initial begin
      step(2);
      chk("rst.lcd_on", 32'(lcd_on), 0);
      chk("rst.lcd_en", 32'(lcd_en), 0);
      chk("rst.lcd_rs", 32'(lcd_rs), 0);
      chk("rst.lcd_data", 32'(lcd_data), 0);
      chk("rst.full", 32'(full), 0);
      chk("rst.busy", 32'(busy), 1);
      chk("rst.init_done", 32'(init_done), 0);
      chk("rst.ovf", 32'(ovf), 0);
      chk("rst.lcd_rw", 32'(lcd_rw), 0);

      rst = 1'b0;
      step(1);
      chk("pwrup.lcd_on", 32'(lcd_on), 1);

      xfer("init0", 8'h38, 1'b0, T_PWRUP + 1 + T_SETUP - 1);
      xfer("init1", 8'h0C, 1'b0, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("init2", 8'h01, 1'b0, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("init3", 8'h06, 1'b0, T_HOLD + T_LONG + 1 + T_SETUP);
      step(T_HOLD + T_EXEC - 1);
      chk("init.done_early", 32'(init_done), 0);
      step(1);
      chk("init.done", 32'(init_done), 1);
      chk("init.idle", 32'(busy), 0);

      wr(9'h141);
      chk("w141.busy", 32'(busy), 1);
      step(1);
      chk("w141.lat_data", 32'(lcd_data), 32'h41);
      chk("w141.lat_rs", 32'(lcd_rs), 1);
      chk("w141.lat_en", 32'(lcd_en), 0);
      xfer("w141", 8'h41, 1'b1, T_SETUP);
      exec_len("w141", T_EXEC);

      wr(9'h001);
      wr(9'h002);
      xfer("w001", 8'h01, 1'b0, T_SETUP);
      xfer("w002", 8'h02, 1'b0, T_HOLD + T_LONG + 1 + T_SETUP);
      exec_len("w002", T_LONG);
      wr(9'h102);
      xfer("w102", 8'h02, 1'b1, -1);
      exec_len("w102", T_EXEC);

      chk("ovf.before", 32'(ovf), 0);
      wr(9'h150);
      wr(9'h151);
      wr(9'h152);
      wr(9'h153);
      wr(9'h154);
      chk("full.four", 32'(full), 1);
      chk("full.cur", 32'(lcd_data), 32'h50);
      step(15);
      chk("full.at_pop", 32'(full), 1);
      chk("full.at_pop_en", 32'(lcd_en), 0);
      wr(9'h1FF);
      chk("full.after_pop", 32'(full), 0);
      chk("ovf.set", 32'(ovf), 1);
      xfer("q51", 8'h51, 1'b1, T_SETUP);
      xfer("q52", 8'h52, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("q53", 8'h53, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("q54", 8'h54, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      exec_len("q54", T_EXEC);

      wr(9'h160);
      step(2);
      chk("abort.pre_en", 32'(lcd_en), 0);
      step(1);
      chk("abort.en_hi", 32'(lcd_en), 1);
      rst = 1'b1;
      #1;
      chk("abort.en_async", 32'(lcd_en), 0);
      chk("abort.lcd_on", 32'(lcd_on), 0);
      chk("abort.busy", 32'(busy), 1);
      chk("abort.ovf", 32'(ovf), 0);
      chk("abort.init_done", 32'(init_done), 0);
      chk("abort.data", 32'(lcd_data), 0);
      @(negedge clk);
      rst = 1'b0;

      wr(9'h141);
      wr(9'h142);
      wr(9'h143);
      wr(9'h144);
      chk("pw.full", 32'(full), 1);
      chk("pw.ovf0", 32'(ovf), 0);
      wr(9'h145);
      wr(9'h146);
      chk("pw.ovf1", 32'(ovf), 1);
      chk("pw.init_done", 32'(init_done), 0);
      xfer("re0", 8'h38, 1'b0, -1);
      xfer("re1", 8'h0C, 1'b0, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("re2", 8'h01, 1'b0, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("re3", 8'h06, 1'b0, T_HOLD + T_LONG + 1 + T_SETUP);
      xfer("pw41", 8'h41, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      chk("pw.init_done1", 32'(init_done), 1);
      xfer("pw42", 8'h42, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("pw43", 8'h43, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      xfer("pw44", 8'h44, 1'b1, T_HOLD + T_EXEC + 1 + T_SETUP);
      exec_len("pw44", T_EXEC);
      step(5);
      chk("pw.no_more", 32'(lcd_en), 0);
      chk("pw.rw", 32'(lcd_rw), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
